// File: rtl/lake_port_fifo.sv
// lake_port_fifo: registered-output synchronous FIFO between a lakespec port and its consumer.
// Define LAKE_PORT_FIFO_OCCUPANCY_EN to add the registered occupancy output.
module lake_port_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     port_in,
  input  logic                      port_in_valid,
  output logic                      port_in_ready,
  output logic [DATA_WIDTH-1:0]     port_out,
  output logic                      port_out_valid,
  input  logic                      port_out_ready
`ifdef LAKE_PORT_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]    occupancy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic                  valid_r;
  logic                  ready_r;
  logic [DATA_WIDTH-1:0] data_r;

  logic                  push_s;
  logic                  pop_s;
  logic [AW-1:0]         wr_ptr_nxt_s;
  logic [AW-1:0]         rd_ptr_nxt_s;
  logic [AW:0]           count_nxt_s;
  logic [AW:0]           count_after_pop_s;
  logic [DATA_WIDTH-1:0] data_nxt_s;

  // Next-state: the head word is precomputed so port_out can come straight from a register.
  always_comb begin
    push_s            = port_in_valid & ready_r;
    pop_s             = valid_r & port_out_ready;
    wr_ptr_nxt_s      = wr_ptr_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    count_nxt_s       = count_r;
    count_after_pop_s = count_r;
    data_nxt_s        = {DATA_WIDTH{1'b0}};

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s      = rd_ptr_r + PTR_ONE;
      count_after_pop_s = count_r - CNT_ONE;
    end else begin
      rd_ptr_nxt_s      = rd_ptr_r;
      count_after_pop_s = count_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // An empty queue after the pop means the incoming word becomes the new head.
    if (count_nxt_s == CNT_ZERO) begin
      data_nxt_s = {DATA_WIDTH{1'b0}};
    end else if (count_after_pop_s == CNT_ZERO) begin
      data_nxt_s = port_in;
    end else begin
      data_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Control and output registers; reset outranks flush, flush outranks any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
      data_r   <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
      data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != CNT_ZERO);
      ready_r  <= (count_nxt_s != CNT_FULL);
      data_r   <= data_nxt_s;
    end
  end

  // Storage needs no reset: port_out is forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_s) begin
      mem_r[wr_ptr_r] <= port_in;
    end
  end

  assign port_in_ready  = ready_r;
  assign port_out_valid = valid_r;
  assign port_out       = data_r;

`ifdef LAKE_PORT_FIFO_OCCUPANCY_EN
  assign occupancy = count_r;
`endif

endmodule
